// File: rtl/spi_frame_slave.sv
// Oversampled SPI slave: streams framed trace words from an internal FIFO to the host
// and captures host bytes. All SPI signals are synchronised into the clk domain.
module spi_frame_slave #(
    parameter int WORD_BYTES  = 2,
    parameter int FRAME_WORDS = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int LED_BITS    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dClk,
    input  logic                    sel,
    input  logic                    rx,
    output logic                    tx,
    input  logic                    sync,
    input  logic [8*WORD_BYTES-1:0] in_word,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7:0]              rx_byte,
    output logic                    rx_valid,
    output logic                    rx_first,
    output logic                    frame_active,
    output logic                    is_transmitting
);

    localparam int WW = 8 * WORD_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t              state_q, state_d;
    logic                dclk_s1_q, dclk_s1_d, dclk_s2_q, dclk_s2_d, dclk_prev_q, dclk_prev_d;
    logic                sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, sel_prev_q, sel_prev_d;
    logic                rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [4:0]          slot_q, slot_d;
    logic [1:0]          bis_q, bis_d;
    logic [4:0]          n_q, n_d;
    logic                loaded_q, loaded_d;
    logic                first_q, first_d;
    logic [7:0]          tx_sh_q, tx_sh_d;
    logic [7:0]          rx_sh_q, rx_sh_d;
    logic [WW-1:0]       word_q, word_d;
    logic [7:0]          rx_byte_q, rx_byte_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_first_q, rx_first_d;
    logic                ovf_q, ovf_d;
    logic [LED_BITS-1:0] led_q, led_d;
    logic [LW-1:0]       count_q, count_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WW-1:0]       fifo_mem_q [FIFO_DEPTH];

    logic          active, rise, fall, samp_edge, shift_edge, sel_fall, full;
    logic          push, pop, ovf_evt, hdr_load, next_load, slot_start;
    logic [4:0]    n_new, slot_idx;
    logic [WW-1:0] cur_word;

    always_comb begin
        active     = !sel_s2_q;
        rise       = dclk_s2_q && !dclk_prev_q;
        fall       = !dclk_s2_q && dclk_prev_q;
        samp_edge  = active && ((CPOL ^ CPHA) ? fall : rise);
        shift_edge = active && ((CPOL ^ CPHA) ? rise : fall);
        sel_fall   = !sel_s2_q && sel_prev_q;
        full       = (count_q == LW'(FIFO_DEPTH));
        n_new      = (int'(count_q) > FRAME_WORDS) ? 5'(FRAME_WORDS) : 5'(count_q);

        dclk_s1_d   = dClk;
        dclk_s2_d   = dclk_s1_q;
        dclk_prev_d = dclk_s2_q;
        sel_s1_d    = sel;
        sel_s2_d    = sel_s1_q;
        sel_prev_d  = sel_s2_q;
        rx_s1_d     = rx;
        rx_s2_d     = rx_s1_q;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        slot_d     = slot_q;
        bis_d      = bis_q;
        n_d        = n_q;
        loaded_d   = loaded_q;
        first_d    = first_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        word_d     = word_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        ovf_d      = ovf_q;
        led_d      = (led_q != '0) ? led_q - 1'b1 : led_q;
        pop        = 1'b0;
        hdr_load   = 1'b0;
        next_load  = 1'b0;
        slot_start = 1'b0;
        slot_idx   = 5'd0;
        cur_word   = '0;

        if (!active) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            slot_d    = 5'd0;
            bis_d     = 2'd0;
            loaded_d  = 1'b0;
            first_d   = 1'b1;
            tx_sh_d   = 8'h00;
        end else begin
            if (samp_edge) begin
                rx_sh_d  = {rx_sh_q[6:0], rx_s2_q};
                loaded_d = 1'b0;
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_d  = 3'd0;
                    rx_byte_d  = {rx_sh_q[6:0], rx_s2_q};
                    rx_valid_d = 1'b1;
                    rx_first_d = first_q;
                    first_d    = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            if (state_q == IDLE) begin
                if (sel_fall) hdr_load = 1'b1;
            end else if (shift_edge) begin
                // At a byte boundary the shift edge either just presents the
                // pre-loaded bit 7 (CPHA=1 header) or loads the next byte.
                loaded_d = 1'b0;
                if (bit_cnt_q != 3'd0) tx_sh_d = {tx_sh_q[6:0], 1'b0};
                else if (!loaded_q)    next_load = 1'b1;
            end

            if (next_load) begin
                if (state_q == HEADER) begin
                    state_d    = PAYLOAD;
                    slot_start = 1'b1;
                    slot_idx   = 5'd0;
                end else if (bis_q == 2'(WORD_BYTES - 1)) begin
                    if (slot_q == 5'(FRAME_WORDS - 1)) begin
                        hdr_load = 1'b1;
                    end else begin
                        slot_start = 1'b1;
                        slot_idx   = slot_q + 5'd1;
                    end
                end else begin
                    bis_d   = bis_q + 2'd1;
                    tx_sh_d = word_q[7:0];
                    word_d  = word_q >> 8;
                end
            end

            if (slot_start) begin
                slot_d = slot_idx;
                bis_d  = 2'd0;
                if (slot_idx < n_q) begin
                    pop      = 1'b1;
                    cur_word = fifo_mem_q[rd_ptr_q];
                end
                tx_sh_d = cur_word[7:0];
                word_d  = cur_word >> 8;
            end

            if (hdr_load) begin
                state_d   = HEADER;
                n_d       = n_new;
                slot_d    = 5'd0;
                bis_d     = 2'd0;
                loaded_d  = 1'b1;
                tx_sh_d   = {n_new != 5'd0, ovf_q, sync, n_new};
                ovf_d     = 1'b0;
                if (n_new != 5'd0) led_d = '1;
            end
        end

        // A full FIFO still accepts a word when a pop frees a slot in the same clk.
        push     = in_valid && (!full || pop);
        ovf_evt  = in_valid && full && !pop;
        if (ovf_evt) ovf_d = 1'b1;
        count_d  = count_q + LW'(push) - LW'(pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dclk_s1_q   <= CPOL;
            dclk_s2_q   <= CPOL;
            dclk_prev_q <= CPOL;
            sel_s1_q    <= 1'b1;
            sel_s2_q    <= 1'b1;
            sel_prev_q  <= 1'b1;
            rx_s1_q     <= 1'b0;
            rx_s2_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            slot_q      <= 5'd0;
            bis_q       <= 2'd0;
            n_q         <= 5'd0;
            loaded_q    <= 1'b0;
            first_q     <= 1'b1;
            tx_sh_q     <= 8'h00;
            rx_sh_q     <= 8'h00;
            word_q      <= '0;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            ovf_q       <= 1'b0;
            led_q       <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            dclk_s1_q   <= dclk_s1_d;
            dclk_s2_q   <= dclk_s2_d;
            dclk_prev_q <= dclk_prev_d;
            sel_s1_q    <= sel_s1_d;
            sel_s2_q    <= sel_s2_d;
            sel_prev_q  <= sel_prev_d;
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            bit_cnt_q   <= bit_cnt_d;
            slot_q      <= slot_d;
            bis_q       <= bis_d;
            n_q         <= n_d;
            loaded_q    <= loaded_d;
            first_q     <= first_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            word_q      <= word_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            ovf_q       <= ovf_d;
            led_q       <= led_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= in_word;
    end

    assign tx              = tx_sh_q[7];
    assign in_ready        = !full;
    assign rx_byte         = rx_byte_q;
    assign rx_valid        = rx_valid_q;
    assign rx_first        = rx_first_q;
    assign frame_active    = !sel_s2_q;
    assign is_transmitting = (led_q != '0);

endmodule
